// File: rtl/led_mode_sequencer.sv
// LED mode sequencer: debounced buttons drive a COUNT/SHIFT/BOUNCE/BREATHE display FSM.
// Define LED_RGB_DIM_EN to dim the RGB indicator LEDs to 1/8 duty.
module led_mode_sequencer #(
  parameter int LOG2DELAY     = 18,
  parameter int DEBOUNCE_BITS = 16,
  parameter int PWM_BITS      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sw,
  input  logic [3:0] btn,
  output logic [3:0] led,
  output logic       led4_r,
  output logic       led4_g,
  output logic       led4_b,
  output logic       led5_r,
  output logic       led5_g,
  output logic       led5_b
);

  localparam logic [1:0] M_COUNT   = 2'd0;
  localparam logic [1:0] M_SHIFT   = 2'd1;
  localparam logic [1:0] M_BOUNCE  = 2'd2;
  localparam logic [1:0] M_BREATHE = 2'd3;

  logic [5:0] meta_q, sync_q;
  logic [1:0] sw_s;
  logic [3:0] btn_s;

  logic [3:0]                    db_q, db_d;
  logic [3:0][DEBOUNCE_BITS-1:0] dbc_q, dbc_d;
  logic [3:0]                    evt_q, evt_d;

  logic [LOG2DELAY-1:0] pre_q, pre_d;
  logic [PWM_BITS-1:0]  pwm_q, pwm_d;
  logic [PWM_BITS-1:0]  duty_q, duty_d;
  logic [3:0]           val_q, val_d;
  logic [3:0]           led_q, led_d;
  logic [1:0]           mode_q, mode_d;
  logic                 run_q, run_d;
  logic                 up_q, up_d;

  logic tick, adv;
  logic [2:0] col4, col5;
  logic rgb_on;

  assign {btn_s, sw_s} = sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {btn, sw};
      sync_q <= meta_q;
    end
  end

  // Level flips only after 2**DEBOUNCE_BITS disagreeing cycles in a row
  always_comb begin
    db_d  = db_q;
    dbc_d = dbc_q;
    evt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (btn_s[i] != db_q[i]) begin
        if (&dbc_q[i]) begin
          db_d[i]  = btn_s[i];
          dbc_d[i] = '0;
          evt_d[i] = btn_s[i];
        end else begin
          dbc_d[i] = dbc_q[i] + DEBOUNCE_BITS'(1);
        end
      end else begin
        dbc_d[i] = '0;
      end
    end
  end

  assign tick = sw_s[1] ? &pre_q[LOG2DELAY-3:0] : &pre_q;
  assign adv  = (tick & run_q) | (evt_q[2] & ~run_q);

  always_comb begin
    mode_d = mode_q;
    run_d  = run_q;
    val_d  = val_q;
    duty_d = duty_q;
    up_d   = up_q;
    pre_d  = pre_q + LOG2DELAY'(1);
    pwm_d  = pwm_q + PWM_BITS'(1);
    if (evt_q[3]) begin
      val_d  = (mode_q == M_SHIFT || mode_q == M_BOUNCE) ? 4'b0001 : 4'b0000;
      duty_d = '0;
      up_d   = 1'b1;
      pre_d  = '0;
    end else if (evt_q[0]) begin
      mode_d = mode_q + 2'd1;
      val_d  = (mode_d == M_SHIFT || mode_d == M_BOUNCE) ? 4'b0001 : 4'b0000;
      duty_d = '0;
      up_d   = 1'b1;
    end else if (evt_q[1]) begin
      run_d = ~run_q;
    end else if (adv) begin
      unique case (mode_q)
        M_COUNT:
          val_d = sw_s[0] ? val_q - 4'd1 : val_q + 4'd1;
        M_SHIFT:
          val_d = sw_s[0] ? {val_q[0], val_q[3:1]}
                          : {val_q[2:0], val_q[3]};
        M_BOUNCE: begin
          if (val_q[3]) begin
            val_d = 4'b0100;
            up_d  = 1'b0;
          end else if (val_q[0]) begin
            val_d = 4'b0010;
            up_d  = 1'b1;
          end else begin
            val_d = up_q ? val_q << 1 : val_q >> 1;
          end
        end
        M_BREATHE: begin
          if (up_q) begin
            duty_d = duty_q + PWM_BITS'(1);
            if (&duty_d) up_d = 1'b0;
          end else begin
            duty_d = duty_q - PWM_BITS'(1);
            if (duty_d == '0) up_d = 1'b1;
          end
        end
      endcase
    end
    led_d = (mode_q == M_BREATHE) ? {4{pwm_q < duty_q}} : val_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_q   <= '0;
      dbc_q  <= '0;
      evt_q  <= '0;
      pre_q  <= '0;
      pwm_q  <= '0;
      duty_q <= '0;
      val_q  <= '0;
      led_q  <= '0;
      mode_q <= M_COUNT;
      run_q  <= 1'b1;
      up_q   <= 1'b1;
    end else begin
      db_q   <= db_d;
      dbc_q  <= dbc_d;
      evt_q  <= evt_d;
      pre_q  <= pre_d;
      pwm_q  <= pwm_d;
      duty_q <= duty_d;
      val_q  <= val_d;
      led_q  <= led_d;
      mode_q <= mode_d;
      run_q  <= run_d;
      up_q   <= up_d;
    end
  end

  always_comb begin
    col4 = 3'b100;
    unique case (mode_q)
      M_COUNT:   col4 = 3'b100;
      M_SHIFT:   col4 = 3'b010;
      M_BOUNCE:  col4 = 3'b001;
      M_BREATHE: col4 = 3'b111;
    endcase
    col5 = run_q ? 3'b010 : 3'b100;
  end

`ifdef LED_RGB_DIM_EN
  logic [2:0] dim_q, dim_d;
  assign dim_d = dim_q + 3'd1;
  always_ff @(posedge clk) begin
    if (!rst_n) dim_q <= '0;
    else        dim_q <= dim_d;
  end
  assign rgb_on = (dim_q == 3'd0);
`else
  assign rgb_on = 1'b1;
`endif

  assign led = led_q;
  assign {led4_r, led4_g, led4_b} = col4 & {3{rgb_on}};
  assign {led5_r, led5_g, led5_b} = col5 & {3{rgb_on}};

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed testbench for led_mode_sequencer (small prescaler/debounce/pwm widths).
// Times are posedges since reset release; inputs change on negedges.
module tb_led_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sw;
  logic [3:0] btn;
  logic [3:0] led;
  logic       led4_r, led4_g, led4_b;
  logic       led5_r, led5_g, led5_b;
  logic [2:0] led4, led5;

  int checks = 0;
  int failures = 0;
  int ecount = 0;

  assign led4 = {led4_r, led4_g, led4_b};
  assign led5 = {led5_r, led5_g, led5_b};

  led_mode_sequencer #(
    .LOG2DELAY(4),
    .DEBOUNCE_BITS(2),
    .PWM_BITS(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw(sw),
    .btn(btn),
    .led(led),
    .led4_r(led4_r),
    .led4_g(led4_g),
    .led4_b(led4_b),
    .led5_r(led5_r),
    .led5_g(led5_g),
    .led5_b(led5_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) ecount <= 0;
    else        ecount <= ecount + 1;
  end

  task automatic at(input int k);
    int guard;
    guard = 0;
    while (ecount < k && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (ecount < k) begin
      failures++;
      $display("FAIL at_timeout got=%0d want=%0d", ecount, k);
    end
  endtask

  task automatic do_reset();
    sw = 2'b00;
    btn = 4'b0000;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_led(input string nm, input logic [3:0] exp);
    checks++;
    if (led !== exp) begin
      failures++;
      $display("FAIL %s t=%0d led got=%b want=%b", nm, ecount, led, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    at(0);
    chk_led("reset_led", 4'b0000);
    checks++;
    if (led4 !== 3'b100) begin
      failures++;
      $display("FAIL reset_led4 got=%b want=100", led4);
    end
    checks++;
    if (led5 !== 3'b010) begin
      failures++;
      $display("FAIL reset_led5 got=%b want=010", led5);
    end
    at(16);
    chk_led("tick_not_yet", 4'b0000);
    at(17);
    chk_led("first_tick", 4'b0001);
  endtask

  task automatic test_count();
    logic [3:0] e;
    do_reset();
    for (int m = 1; m <= 17; m++) begin
      at(16 * m + 8);
      e = 4'(m);
      chk_led("count_up", e);
    end
    checks++;
    if (led4 !== 3'b100) begin
      failures++;
      $display("FAIL count_led4 got=%b want=100", led4);
    end
    sw = 2'b01;
    at(296);
    chk_led("count_down_0", 4'b0000);
    at(312);
    chk_led("count_wrap_down", 4'b1111);
  endtask

  task automatic test_glitch();
    do_reset();
    at(2);  btn[0] = 1'b1;
    at(5);  btn[0] = 1'b0;
    at(14);
    chk_led("glitch_led", 4'b0000);
    checks++;
    if (led4 !== 3'b100) begin
      failures++;
      $display("FAIL glitch_led4 got=%b want=100", led4);
    end
    at(20); btn[0] = 1'b1;
    at(30); btn[0] = 1'b0;
    chk_led("mode_shift_led", 4'b0001);
    checks++;
    if (led4 !== 3'b010) begin
      failures++;
      $display("FAIL mode_shift_led4 got=%b want=010", led4);
    end
    at(40);
    chk_led("shift_after_release", 4'b0010);
    checks++;
    if (led4 !== 3'b010) begin
      failures++;
      $display("FAIL release_led4 got=%b want=010", led4);
    end
  endtask

  task automatic test_pause_step();
    do_reset();
    at(2);  btn[1] = 1'b1;
    at(8);  btn[1] = 1'b0;
    at(10);
    checks++;
    if (led5 !== 3'b100) begin
      failures++;
      $display("FAIL paused_led5 got=%b want=100", led5);
    end
    chk_led("paused_led", 4'b0000);
    at(74);
    chk_led("paused_frozen", 4'b0000);
    at(80); btn[2] = 1'b1;
    at(86); btn[2] = 1'b0;
    at(100);
    chk_led("step_one", 4'b0001);
    at(120); btn[1] = 1'b1;
    at(126); btn[1] = 1'b0;
    chk_led("step_hold", 4'b0001);
    at(130);
    checks++;
    if (led5 !== 3'b010) begin
      failures++;
      $display("FAIL resumed_led5 got=%b want=010", led5);
    end
    chk_led("resumed_tick", 4'b0010);
    at(132); btn[2] = 1'b1;
    at(138); btn[2] = 1'b0;
    at(150);
    chk_led("step_ignored_running", 4'b0011);
  endtask

  task automatic test_priority();
    do_reset();
    at(2);  btn[0] = 1'b1;
    at(8);  btn[0] = 1'b0;
    at(34);
    chk_led("shift_0100", 4'b0100);
    btn = 4'b1001;
    at(40); btn = 4'b0000;
    at(43);
    chk_led("clear_wins", 4'b0001);
    checks++;
    if (led4 !== 3'b010) begin
      failures++;
      $display("FAIL clear_mode_kept got=%b want=010", led4);
    end
    at(56);
    chk_led("prescaler_cleared", 4'b0001);
    at(60);
    chk_led("tick_after_clear", 4'b0010);
    at(100);
    chk_led("shift_1000", 4'b1000);
    at(110);
    chk_led("shift_wrap_left", 4'b0001);
    sw = 2'b01;
    at(125);
    chk_led("shift_wrap_right", 4'b1000);
    at(140);
    chk_led("shift_right", 4'b0100);
  endtask

  task automatic test_bounce();
    logic [3:0] exp_seq [8];
    exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                4'b0010, 4'b0001, 4'b0010, 4'b0100};
    do_reset();
    at(2);  btn[0] = 1'b1;
    at(8);  btn[0] = 1'b0;
    at(14); btn[0] = 1'b1;
    at(20); btn[0] = 1'b0;
    at(24);
    chk_led("bounce_init", 4'b0001);
    checks++;
    if (led4 !== 3'b001) begin
      failures++;
      $display("FAIL bounce_led4 got=%b want=001", led4);
    end
    sw = 2'b01;
    for (int m = 2; m <= 9; m++) begin
      at(16 * m + 8);
      chk_led("bounce_walk", exp_seq[m-2]);
    end
  endtask

  task automatic test_breathe();
    int hi, bad;
    do_reset();
    at(2);  btn[0] = 1'b1;
    at(8);  btn[0] = 1'b0;
    at(14); btn[0] = 1'b1;
    at(20); btn[0] = 1'b0;
    at(26); btn[0] = 1'b1;
    at(32); btn[0] = 1'b0;
    at(34);
    checks++;
    if (led4 !== 3'b111) begin
      failures++;
      $display("FAIL breathe_led4 got=%b want=111", led4);
    end
    bad = 0;
    for (int k = 34; k <= 48; k++) begin
      at(k);
      if (led !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL breathe_dark lit=%0d want=0", bad);
    end
    hi = 0;
    bad = 0;
    for (int k = 273; k <= 288; k++) begin
      at(k);
      if (led === 4'b1111) hi++;
      else if (led !== 4'b0000) bad++;
    end
    checks++;
    if (hi != 15 || bad != 0) begin
      failures++;
      $display("FAIL breathe_duty15 high=%0d bad=%0d want=15/0", hi, bad);
    end
    hi = 0;
    bad = 0;
    for (int k = 289; k <= 304; k++) begin
      at(k);
      if (led === 4'b1111) hi++;
      else if (led !== 4'b0000) bad++;
    end
    checks++;
    if (hi != 14 || bad != 0) begin
      failures++;
      $display("FAIL breathe_duty14 high=%0d bad=%0d want=14/0", hi, bad);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sw = 2'b00;
    btn = 4'b0000;
    test_reset();
    test_count();
    test_glitch();
    test_pause_step();
    test_priority();
    test_bounce();
    test_breathe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
